// File: rtl/aes_pkg.sv
// Shared AES round-pipeline types: state/column typedefs, sequencer FSM
// encoding, latency constants and column slice helpers.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } mixcol_state_e;

  localparam int LAT_FWD = 4;
  localparam int LAT_INV = 8;

  // Column c occupies bits [127-32c -: 32]; byte 0 of a column is its MSB byte.
  function automatic col_t get_col(input state_t s, input logic [1:0] c);
    return s[127 - 32*int'(c) -: 32];
  endfunction

  function automatic state_t set_col(input state_t s, input logic [1:0] c, input col_t v);
    state_t r;
    r = s;
    r[127 - 32*int'(c) -: 32] = v;
    return r;
  endfunction

endpackage

// File: rtl/mix_columns.sv
// Single-column AES MixColumns datapath; i_inv_en selects the InvMixColumns
// pre-step (forward MixColumns of that result gives InvMixColumns).
module mix_columns
  import aes_pkg::*;
(
  input  col_t i_col,
  input  logic i_inv_en,
  output col_t o_col
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_t, w_u, w_v;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign w_t = w_a0 ^ w_a1 ^ w_a2 ^ w_a3;
  assign w_u = xtime(xtime(w_a0 ^ w_a2));
  assign w_v = xtime(xtime(w_a1 ^ w_a3));

  always_comb begin
    if (i_inv_en) begin
      o_col = {w_a0 ^ w_u, w_a1 ^ w_v, w_a2 ^ w_u, w_a3 ^ w_v};
    end else begin
      o_col = {w_a0 ^ w_t ^ xtime(w_a0 ^ w_a1),
               w_a1 ^ w_t ^ xtime(w_a1 ^ w_a2),
               w_a2 ^ w_t ^ xtime(w_a2 ^ w_a3),
               w_a3 ^ w_t ^ xtime(w_a3 ^ w_a0)};
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial MixColumns/InvMixColumns sequencer around one mix_columns.
// Optional final-round bypass port in_skip when MIXCOL_SEQ_SKIP_EN is defined.
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; in_ready is high only in IDLE, out_valid only in DONE, and out_state is
// held stable while out_valid is high and out_ready is low.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     in_state,
  input  logic       in_inv,
`ifdef MIXCOL_SEQ_SKIP_EN
  input  logic       in_skip,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     out_state,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] LAST_COL = 2'(COLS - 1);

  mixcol_state_e r_state, w_state_next;
  logic [1:0]    r_col_cnt;
  state_t        r_work;
  logic          r_inv;
  logic          w_skip;
  logic          w_inv_en;
  col_t          w_col_in, w_col_out;

`ifdef MIXCOL_SEQ_SKIP_EN
  assign w_skip = in_skip;
`else
  assign w_skip = 1'b0;
`endif

  assign w_inv_en = (r_state == PRE) && r_inv;
  assign w_col_in = get_col(r_work, r_col_cnt);

  mix_columns u_mix_columns (
    .i_col    (w_col_in),
    .i_inv_en (w_inv_en),
    .o_col    (w_col_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_next = w_skip ? DONE : (in_inv ? PRE : MIX);
      PRE:  if (r_col_cnt == LAST_COL) w_state_next = MIX;
      MIX:  if (r_col_cnt == LAST_COL) w_state_next = DONE;
      DONE: if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Working register and column counter; both frozen in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work    <= '0;
      r_inv     <= 1'b0;
      r_col_cnt <= 2'd0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_work    <= in_state;
          r_inv     <= in_inv;
          r_col_cnt <= 2'd0;
        end
        PRE, MIX: begin
          r_work    <= set_col(r_work, r_col_cnt, w_col_out);
          r_col_cnt <= (r_col_cnt == LAST_COL) ? 2'd0 : r_col_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign out_state = r_work;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed + randomized bench for mix_columns_seq against a GF(2^8) reference.
// Covers the MIXCOL_SEQ_SKIP_EN bypass when that macro is defined.
module tb_mix_columns_seq;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  state_t     in_state;
  logic       in_inv;
  logic       out_valid;
  logic       out_ready;
  state_t     out_state;
  logic       busy;
  logic [1:0] dbg_state;
`ifdef MIXCOL_SEQ_SKIP_EN
  logic       in_skip;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_inv    (in_inv),
`ifdef MIXCOL_SEQ_SKIP_EN
    .in_skip   (in_skip),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: textbook matrix products over GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic state_t ref_mix(input state_t s, input logic inv);
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [7:0] b;
    state_t r;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(a[j], coef[(j - i) & 3]);
        r[127 - 32*c - 8*i -: 8] = b;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents one state, returns just after the accept edge.
  task automatic send(input state_t s, input logic inv, input logic skip);
    int guard = 0;
    in_state = s;
    in_inv   = inv;
`ifdef MIXCOL_SEQ_SKIP_EN
    in_skip  = skip;
`else
    if (skip) $display("skip request ignored in this build");
`endif
    in_valid = 1'b1;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Number of edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovalid_after"}, 128'(out_valid), 128'(1'b0));
    chk({tag, "_iready_after"}, 128'(in_ready), 128'(1'b1));
  endtask

  task automatic run_one(input string tag, input state_t s, input logic inv, input state_t exp);
    int lat;
    send(s, inv, 1'b0);
    wait_out(lat);
    chk({tag, "_lat"}, 128'(lat), 128'(inv ? LAT_INV : LAT_FWD));
    chk({tag, "_data"}, out_state, exp);
    drain(tag);
  endtask

  state_t v_fwd_in, v_fwd_out, v_a, v_b, v_hold, v_rand;
  logic   v_inv;
  int     v_lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_inv = 1'b0; out_ready = 1'b0;
`ifdef MIXCOL_SEQ_SKIP_EN
    in_skip = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_out_state", out_state, 128'h0);
    chk("rst_dbg_state", 128'(dbg_state), 128'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer vectors, forward then back through the inverse.
    v_fwd_in  = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    v_fwd_out = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    chk("kat_model", ref_mix(v_fwd_in, 1'b0), v_fwd_out);
    run_one("kat_fwd", v_fwd_in, 1'b0, v_fwd_out);
    run_one("kat_inv", v_fwd_out, 1'b1, v_fwd_in);

    for (int i = 0; i < 8; i++) begin
      v_rand = {$urandom, $urandom, $urandom, $urandom};
      v_inv  = 1'($urandom_range(0, 1));
      run_one($sformatf("rand%0d", i), v_rand, v_inv, ref_mix(v_rand, v_inv));
    end

    // Backpressure: output held, in_valid pulse ignored.
    v_a = {$urandom, $urandom, $urandom, $urandom};
    send(v_a, 1'b1, 1'b0);
    wait_out(v_lat);
    chk("bp_lat", 128'(v_lat), 128'(LAT_INV));
    v_hold = ref_mix(v_a, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        in_valid = 1'b1; in_inv = 1'b0; in_state = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("bp_data%0d", k), out_state, v_hold);
      chk($sformatf("bp_iready%0d", k), 128'(in_ready), 128'(1'b0));
      chk($sformatf("bp_ovalid%0d", k), 128'(out_valid), 128'(1'b1));
    end
    in_valid = 1'b0;
    drain("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_accept", 128'(busy), 128'(1'b0));

    // Back-to-back with in_valid held and out_ready held high.
    v_a = {$urandom, $urandom, $urandom, $urandom};
    v_b = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    in_valid  = 1'b1; in_inv = 1'b0; in_state = v_a;
    @(posedge clk); #1;
    in_state = v_b;
    wait_out(v_lat);
    chk("b2b_lat_a", 128'(v_lat), 128'(LAT_FWD));
    chk("b2b_data_a", out_state, ref_mix(v_a, 1'b0));
    @(posedge clk); #1;
    chk("b2b_hs_ovalid", 128'(out_valid), 128'(1'b0));
    chk("b2b_hs_iready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_accept_b", 128'(busy), 128'(1'b1));
    wait_out(v_lat);
    chk("b2b_lat_b", 128'(v_lat), 128'(LAT_FWD));
    chk("b2b_data_b", out_state, ref_mix(v_b, 1'b0));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_done_b", 128'(out_valid), 128'(1'b0));

    // Asynchronous reset during MIX with col_cnt = 2.
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ovalid", 128'(out_valid), 128'(1'b0));
    chk("arst_iready", 128'(in_ready), 128'(1'b1));
    chk("arst_busy", 128'(busy), 128'(1'b0));
    chk("arst_state", out_state, 128'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    v_a = {$urandom, $urandom, $urandom, $urandom};
    run_one("arst_after", v_a, 1'b0, ref_mix(v_a, 1'b0));

`ifdef MIXCOL_SEQ_SKIP_EN
    v_a = {$urandom, $urandom, $urandom, $urandom};
    send(v_a, 1'b1, 1'b1);
    in_skip = 1'b0;
    wait_out(v_lat);
    chk("skip_lat", 128'(v_lat), 128'(1));
    chk("skip_data", out_state, v_a);
    drain("skip");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequencer that applies AES MixColumns or InvMixColumns to a full 128-bit state by time-multiplexing one shared `mix_columns` column datapath, one column per cycle. It sits between the ShiftRows/SubBytes stage and AddRoundKey in the round pipeline. It uses a valid/ready handshake on both sides and holds one state at a time.

## Interface
- `COLS`, default 4: columns per state; fixes the column counter width at 2 bits. Only 4 is supported.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_state` and `in_inv` are valid.
- `in_ready` output 1: block can accept a state; high only in IDLE.
- `in_state` input 128: AES state. Column c = bits [127-32c -: 32]; byte 0 of a column is at its [31:24].
- `in_inv` input 1: 0 selects MixColumns, 1 selects InvMixColumns. Latched at accept.
- `out_valid` output 1: `out_state` holds the result.
- `out_ready` input 1: the downstream stage accepts the result.
- `out_state` output 128: result, same column layout as `in_state`.
- `busy` output 1: high in every state except IDLE.

## Operation
- Shared `mix_columns` instance, one column per cycle:
  - With `inv_en`=0 it computes the forward MixColumns.
  - With `inv_en`=1 it computes the InvMixColumns pre-step, per column (a0..a3): u = xtime(xtime(a0^a2)), v = xtime(xtime(a1^a3)), output (a0^u, a1^v, a2^u, a3^v).
  - InvMixColumns = forward MixColumns applied to the pre-step output.
- FSM states: IDLE, PRE, MIX, DONE.
  - IDLE: accept when `in_valid`&&`in_ready`. Load `in_state` into the 128-bit working register, latch inv, clear col_cnt. Go to PRE if inv, else MIX.
  - PRE: drive column col_cnt with `inv_en`=1 and write the result back into that column. At col_cnt=3, wrap col_cnt to 0 and go to MIX; otherwise increment col_cnt.
  - MIX: drive column col_cnt with `inv_en`=0 and write back. At col_cnt=3 go to DONE; otherwise increment col_cnt.
  - DONE: `out_valid`=1 and `out_state` = working register. Go to IDLE when `out_ready` is sampled high.
- The working register and latched inv do not change in DONE; the output is stable while `out_valid` is high and `out_ready` is low.
- `in_valid` is ignored outside IDLE. There is no buffering and no accept in the same cycle as the output handshake.
- The column mux is indexed by col_cnt only. Columns 0..3 are always processed in ascending order.

## Timing
- Reset values: FSM=IDLE, col_cnt=0, working register=0, inv=0. Outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `out_state`=0.
- Reset asserted mid-operation aborts the state immediately, without waiting for a clock edge. Nothing is emitted and `out_valid` drops asynchronously.
- Latency is counted from the accept edge T:
  - Forward: MIX on edges T+1..T+4; `out_valid` high after T+4, i.e. 4 cycles.
  - Inverse: PRE on T+1..T+4, MIX on T+5..T+8; `out_valid` high after T+8.
- Output handshake at edge D returns the FSM to IDLE. `in_ready` is high after D, so the earliest next accept is D+1.
- Minimum interval between accepts: 6 cycles forward, 10 cycles inverse.
- `out_ready` held high before `out_valid`: the handshake completes on the first DONE edge.

## Configuration
- `MIXCOL_SEQ_SKIP_EN` defined:
  - Adds input `in_skip` (1 bit), latched at accept. It is used for the final round, which has no MixColumns.
  - When `in_skip` is 1, IDLE goes directly to DONE and the state passes through unchanged, giving 1-cycle latency. `in_skip` overrides `in_inv`.
- `MIXCOL_SEQ_SKIP_EN` not defined: the port is absent and there is no skip path. Behaviour is otherwise identical.

## Structure
- Shared package `aes_pkg` holds:
  - the 128-bit state typedef and 32-bit column typedef;
  - the FSM enum (IDLE/PRE/MIX/DONE);
  - the latency constants (4 forward, 8 inverse);
  - the column slice helper function.
- Exactly one sub-module: the existing `mix_columns`, instantiated once. The block itself contains no GF arithmetic.

## Test plan
- Forward: columns db135345, f20a225c, 01010101, d4d4d4d5 → 8e4da1bc, 9fdc589d, 01010101, d5d5d7d6. `out_valid` rises exactly 4 cycles after accept.
- Inverse: the forward outputs above fed back with `in_inv`=1 → original columns restored. `out_valid` rises exactly 8 cycles after accept.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. `out_state` stays stable, `in_ready` stays 0, and a pulse on `in_valid` is not accepted.
- Back-to-back: keep `in_valid` high with two states queued. The second accept occurs exactly 1 cycle after the output handshake; both results are correct.
- Reset mid-MIX (forward, col_cnt=2): `out_valid` is 0 and `in_ready` is 1 immediately. A new state afterwards yields the correct result with no leftover from the aborted one.
- `MIXCOL_SEQ_SKIP_EN` build with `in_skip`=1 and `in_inv`=1: `out_state` equals `in_state` bit-exact, and `out_valid` is high 1 cycle after accept.
